// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice
// LSB-first over WIDTH cycles, plus one extra SLT resolve cycle.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, op, a, b     request (sampled when ready), opcode, operands
//   ready, done         accepting / one-cycle completion pulse
//   result, zero        WIDTH-bit result and zero flag
//   carry_out, overflow add/sub carry and signed overflow
//   err                 illegal opcode, valid with done
//   slice_ai/bi/ci/less slice data inputs
//   slice_aluop0..2     slice op inputs
//   slice_ri, slice_cinext  slice result bit and carry out
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             err,
  output logic             slice_ai,
  output logic             slice_bi,
  output logic             slice_ci,
  output logic             slice_less,
  output logic             slice_aluop0,
  output logic             slice_aluop1,
  output logic             slice_aluop2,
  input  logic             slice_ri,
  input  logic             slice_cinext
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SLT,
    DONE
  } state_t;

  state_t st, st_nx;

  logic [WIDTH-1:0] a_q, b_q, sh, sh_nx;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx;
  logic             cy, cin_msb, sum_msb;
  logic             legal, acc, last, is_slt, arith;
  logic [2:0]       aluop;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (op == 3'b000): legal = 1'b1;
      (op == 3'b001): legal = 1'b1;
      (op == 3'b010): legal = 1'b1;
      (op == 3'b110): legal = 1'b1;
      (op == 3'b111): legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  assign ready  = (st == IDLE) || (st == DONE);
  assign done   = (st == DONE);
  assign acc    = ready && start;
  assign last   = (idx == IW'(WIDTH - 1));
  assign is_slt = (op_q == 3'b111);
  assign arith  = (op_q[1:0] == 2'b10);

  // slt walks the word as a subtract, then resolves in SLT
  always_comb begin
    slice_ai   = 1'b0;
    slice_bi   = 1'b0;
    slice_ci   = 1'b0;
    slice_less = 1'b0;
    aluop      = 3'b000;
    unique case (st)
      RUN: begin
        slice_ai = a_q[idx];
        slice_bi = b_q[idx];
        slice_ci = cy;
        aluop    = is_slt ? 3'b110 : op_q;
      end
      SLT: begin
        slice_ai   = a_q[0];
        slice_bi   = b_q[0];
        slice_ci   = 1'b1;
        slice_less = sum_msb ^ (cin_msb ^ cy);
        aluop      = 3'b111;
      end
      default: ;
    endcase
  end

  assign slice_aluop0 = aluop[0];
  assign slice_aluop1 = aluop[1];
  assign slice_aluop2 = aluop[2];

  always_comb begin
    sh_nx      = sh;
    sh_nx[idx] = slice_ri;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (start) st_nx = legal ? RUN : DONE;
      RUN:  if (last) st_nx = is_slt ? SLT : DONE;
      SLT:  st_nx = DONE;
      DONE: begin
        if (start) st_nx = legal ? RUN : DONE;
        else       st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      sh        <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      cin_msb   <= 1'b0;
      sum_msb   <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (st)
        IDLE, DONE: begin
          if (acc && legal) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cy   <= op[2];
            idx  <= '0;
            sh   <= '0;
          end else if (acc) begin
            result    <= '0;
            zero      <= 1'b1;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b1;
          end
        end
        RUN: begin
          sh  <= sh_nx;
          cy  <= slice_cinext;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            cin_msb <= cy;
            sum_msb <= slice_ri;
            if (!is_slt) begin
              result    <= sh_nx;
              zero      <= ~|sh_nx;
              carry_out <= arith & slice_cinext;
              overflow  <= arith & (cy ^ slice_cinext);
              err       <= 1'b0;
            end
          end
        end
        SLT: begin
          result    <= {{(WIDTH-1){1'b0}}, slice_ri};
          zero      <= ~slice_ri;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          err       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl with a behavioural 1-bit slice.
// Vector table plus scoreboard, with reset and ignored-start sequences.
module tb_bit_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, zero, carry_out, overflow, err;
  logic [W-1:0] result;
  logic         s_ai, s_bi, s_ci, s_less;
  logic         s_op0, s_op1, s_op2;
  logic         s_ri, s_cn;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .zero(zero),
    .carry_out(carry_out), .overflow(overflow), .err(err),
    .slice_ai(s_ai), .slice_bi(s_bi), .slice_ci(s_ci),
    .slice_less(s_less), .slice_aluop0(s_op0),
    .slice_aluop1(s_op1), .slice_aluop2(s_op2),
    .slice_ri(s_ri), .slice_cinext(s_cn)
  );

  always #5 clk = ~clk;

  logic s_be;
  always_comb begin
    s_be = s_bi ^ s_op2;
    s_cn = (s_ai & s_be) | (s_ai & s_ci) | (s_be & s_ci);
    s_ri = 1'b0;
    case ({s_op1, s_op0})
      2'b00: s_ri = s_ai & s_be;
      2'b01: s_ri = s_ai | s_be;
      2'b10: s_ri = s_ai ^ s_be ^ s_ci;
      default: s_ri = s_less;
    endcase
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z, c, v, e;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         z, c, v, e;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, ex, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("result", 32'(result), 32'(me.r));
        chk("zero", 32'(zero), 32'(me.z));
        chk("carry_out", 32'(carry_out), 32'(me.c));
        chk("overflow", 32'(overflow), 32'(me.v));
        chk("err", 32'(err), 32'(me.e));
        chk("latency", 32'(cyc), 32'(me.due));
        chk("ready_in_done", 32'(ready), 1);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input exp_t e,
                       input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.due = cyc + lat;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  // Independent arithmetic reference for random vectors
  function automatic exp_t model(input logic [2:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    e.r = '0; e.c = 0; e.v = 0; e.e = 0; e.due = 0;
    case (o)
      3'b000: e.r = x & y;
      3'b001: e.r = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b110: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b111: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
      default: e.e = 1;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  function automatic exp_t mk(input vec_t v);
    exp_t e;
    e.r = v.r; e.z = v.z; e.c = v.c; e.v = v.v; e.e = v.e; e.due = 0;
    return e;
  endfunction

  vec_t       tbl[13];
  logic [2:0] legal_ops[5];
  exp_t       ex;

  initial begin
    tbl[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 0, 8};
    tbl[1]  = '{3'b110, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0, 8};
    tbl[2]  = '{3'b111, 8'h80, 8'h01, 8'h01, 0, 0, 0, 0, 9};
    tbl[3]  = '{3'b111, 8'h01, 8'h80, 8'h00, 1, 0, 0, 0, 9};
    tbl[4]  = '{3'b000, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 8};
    tbl[5]  = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 0, 8};
    tbl[6]  = '{3'b100, 8'h12, 8'h34, 8'h00, 1, 0, 0, 1, 0};
    tbl[7]  = '{3'b010, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 8};
    tbl[8]  = '{3'b110, 8'h03, 8'h05, 8'hFE, 0, 0, 0, 0, 8};
    tbl[9]  = '{3'b110, 8'h80, 8'h01, 8'h7F, 0, 1, 1, 0, 8};
    tbl[10] = '{3'b011, 8'hAA, 8'h55, 8'h00, 1, 0, 0, 1, 0};
    tbl[11] = '{3'b111, 8'hFF, 8'h00, 8'h01, 0, 0, 0, 0, 9};
    tbl[12] = '{3'b101, 8'h01, 8'h01, 8'h00, 1, 0, 0, 1, 0};
    legal_ops[0] = 3'b000;
    legal_ops[1] = 3'b001;
    legal_ops[2] = 3'b010;
    legal_ops[3] = 3'b110;
    legal_ops[4] = 3'b111;

    #12;
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_flags", {carry_out, overflow, err}, 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_slice", {s_ai, s_bi, s_ci, s_less, s_op0, s_op1, s_op2}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      issue(tbl[i].op, tbl[i].a, tbl[i].b, mk(tbl[i]), tbl[i].lat);
    drain();

    for (int i = 0; i < 16; i++) begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      o = legal_ops[$urandom_range(0, 4)];
      x = W'($urandom);
      y = W'($urandom);
      ex = model(o, x, y);
      issue(o, x, y, ex, (o == 3'b111) ? 9 : 8);
    end
    drain();

    ex = model(3'b010, 8'h12, 8'h34);
    issue(3'b010, 8'h12, 8'h34, ex, 8);
    repeat (3) @(negedge clk);
    op = 3'b000;
    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    ex = model(3'b010, 8'h55, 8'h0A);
    issue(3'b010, 8'h55, 8'h0A, ex, 8);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_zero", 32'(zero), 1);
    chk("mid_rst_flags", {carry_out, overflow, err}, 0);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_slice", {s_ai, s_bi, s_ci, s_less, s_op0, s_op1, s_op2}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 0);
    end
    ex = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    issue(3'b010, 8'h01, 8'h02, ex, 8);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
